// File: rtl/bus_arbiter_2m_pkg.sv
// Shared definitions for the two-master bus arbiter.
// Contents: bus widths, the default watchdog limit and error read data,
// and the arbiter FSM state encoding (also exposed on the debug port).
package bus_arbiter_2m_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  localparam int                DEFAULT_TIMEOUT_CYCLES = 255;
  localparam logic [DATA_W-1:0] DEFAULT_ERR_DATA       = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/bus_arbiter_2m_if.sv
// One memory-mapped bus channel (request side + response side).
//
// Handshake: the requester raises rd_en and/or wr_en with addr/wdata/
// byte_enable and holds all of them steady until the responder pulses ack
// for exactly one cycle. rdata and err are meaningful only while ack is
// high. Dropping rd_en/wr_en before ack withdraws the request.
//
// Modports:
//   master : drives the request, receives rdata/ack/err
//   slave  : receives the request, drives rdata/ack/err
// The slave-side bus carries no err; only master channels use it.
interface bus_arbiter_2m_if;
  import bus_arbiter_2m_pkg::*;

  logic              rd_en;
  logic              wr_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [BE_W-1:0]   byte_enable;
  logic [DATA_W-1:0] rdata;
  logic              ack;
  logic              err;

  modport master (
    output rd_en, wr_en, addr, wdata, byte_enable,
    input  rdata, ack
  );

  modport slave (
    input  rd_en, wr_en, addr, wdata, byte_enable,
    output rdata, ack, err
  );

endinterface

// File: rtl/bus_arbiter_2m_watchdog.sv
// Grant watchdog: counts cycles spent in a grant and flags the last
// allowed cycle.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   i_clear     hold the count at zero (asserted while the arbiter is idle)
//   i_enable    count one cycle (asserted while a grant is active)
//   o_expired   count has reached TIMEOUT_CYCLES-1
module bus_arbiter_2m_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_count;

  // The arbiter leaves the grant on the limit cycle, so the count never
  // needs to saturate; any wrap on that final increment is cleared in idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_expired = (r_count == LIMIT);

endmodule

// File: rtl/bus_arbiter_2m.sv
// Two-master round-robin arbiter in front of a single slave bus.
// A grant covers one whole transaction and is held until the slave acks;
// the watchdog turns a missing ack into an error ack for the master.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   m0, m1         master channels (M0 = core, M1 = boot loader / DMA)
//   s              slave bus towards the address decode / ack mux
//   o_dbg_state    current arbiter state
module bus_arbiter_2m
  import bus_arbiter_2m_pkg::*;
#(
  parameter int                TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter logic [DATA_W-1:0] ERR_DATA       = DEFAULT_ERR_DATA
) (
  input  logic                    clk,
  input  logic                    rst_n,
  bus_arbiter_2m_if.slave         m0,
  bus_arbiter_2m_if.slave         m1,
  bus_arbiter_2m_if.master        s,
  output arb_state_e              o_dbg_state
);

  arb_state_e r_state;
  logic       r_last_grant;

  logic w_req0;
  logic w_req1;
  logic w_idle;
  logic w_gnt0;
  logic w_gnt1;
  logic w_req_gnt;
  logic w_expired;
  logic w_timeout;

  assign w_req0    = m0.rd_en | m0.wr_en;
  assign w_req1    = m1.rd_en | m1.wr_en;
  assign w_idle    = (r_state == ST_IDLE);
  assign w_gnt0    = (r_state == ST_GNT0);
  assign w_gnt1    = (r_state == ST_GNT1);
  assign w_req_gnt = (w_gnt0 & w_req0) | (w_gnt1 & w_req1);
  // A real ack on the limit cycle wins; a withdrawn request is an abort,
  // not a timeout.
  assign w_timeout = w_expired & w_req_gnt & ~s.ack;

  bus_arbiter_2m_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_idle),
    .i_enable (w_gnt0 | w_gnt1),
    .o_expired(w_expired)
  );

  // Every transaction returns through IDLE, which gives the mandatory
  // idle cycle between grants and keeps request decoding in one place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;  // M0 wins the first contended request
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req0 && w_req1) begin
            r_state <= r_last_grant ? ST_GNT0 : ST_GNT1;
          end else if (w_req0) begin
            r_state <= ST_GNT0;
          end else if (w_req1) begin
            r_state <= ST_GNT1;
          end
        end
        ST_GNT0, ST_GNT1: begin
          if (s.ack || w_timeout) begin
            r_state      <= ST_IDLE;
            r_last_grant <= w_gnt1;
          end else if (!w_req_gnt) begin
            r_state <= ST_IDLE;  // abort: fairness history untouched
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Pass-through muxing; idle (and therefore reset) drives everything to 0.
  always_comb begin
    s.rd_en       = 1'b0;
    s.wr_en       = 1'b0;
    s.addr        = '0;
    s.wdata       = '0;
    s.byte_enable = '0;
    m0.ack        = 1'b0;
    m0.err        = 1'b0;
    m0.rdata      = '0;
    m1.ack        = 1'b0;
    m1.err        = 1'b0;
    m1.rdata      = '0;
    if (w_gnt0) begin
      s.rd_en       = m0.rd_en & ~w_timeout;
      s.wr_en       = m0.wr_en & ~w_timeout;
      s.addr        = m0.addr;
      s.wdata       = m0.wdata;
      s.byte_enable = m0.byte_enable;
      m0.ack        = s.ack | w_timeout;
      m0.err        = w_timeout;
      m0.rdata      = w_timeout ? ERR_DATA : s.rdata;
    end else if (w_gnt1) begin
      s.rd_en       = m1.rd_en & ~w_timeout;
      s.wr_en       = m1.wr_en & ~w_timeout;
      s.addr        = m1.addr;
      s.wdata       = m1.wdata;
      s.byte_enable = m1.byte_enable;
      m1.ack        = s.ack | w_timeout;
      m1.err        = w_timeout;
      m1.rdata      = w_timeout ? ERR_DATA : s.rdata;
    end
  end

  assign o_dbg_state = r_state;

endmodule
